// File: rtl/dpad_direction_encoder.sv
// dpad_direction_encoder
//   Turns four raw push-buttons into the one-hot heading bus used by the
//   snake game core. Each button is synchronised (2 FF) and debounced; a
//   debounced 0->1 edge is a direction request. The latest request is held
//   as pending and committed to `direction` only on a `step` pulse, so the
//   heading changes at most once per snake move.
//
//   Optional build macro: DPAD_REVERSAL_BLOCK_EN
//     defined   -> a pending heading exactly opposite the current one is
//                  discarded at commit (head may not turn into the body)
//     undefined -> every pending heading commits
//
// Ports
//   clk         in   board clock, rising edge
//   reset       in   synchronous, active-high
//   l, r, u, d  in   raw asynchronous buttons, active-high
//   step        in   one-cycle move pulse from the game core
//   direction   out  [3:0] committed heading: 0001 L, 0010 R, 0100 D, 1000 U
//   dir_changed out  one-cycle pulse while a new `direction` is first visible
module dpad_direction_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       step,
  output logic [3:0] direction,
  output logic       dir_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order matches the direction encoding: {up, down, right, left}
  logic [3:0]       raw;
  logic [3:0]       sync0;
  logic [3:0]       sync1;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       rise;

  logic [3:0] req;
  logic       req_v;
  logic [3:0] pend;
  logic       pend_v;
  logic [3:0] opp_dir;
  logic       commit;
  logic       block_hit;
  logic       take;

  assign raw = {u, d, r, l};

  // Synchroniser and per-button debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0  <= '0;
      sync1  <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A request is flagged in the cycle whose edge accepts a new high level,
  // so it lands in `pend` on the same edge that `stable` rises.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < 4; i++)
      rise[i] = sync1[i] & ~stable[i] & (cnt[i] == CNT_LAST);
  end

  // Same-cycle rises: left > right > up > down
  always_comb begin
    req   = '0;
    req_v = |rise;
    if (rise[0])      req = 4'b0001;
    else if (rise[1]) req = 4'b0010;
    else if (rise[3]) req = 4'b1000;
    else if (rise[2]) req = 4'b0100;
  end

  // Commit decision
  always_comb begin
    opp_dir = {direction[2], direction[3], direction[0], direction[1]};
    commit  = step & pend_v;
`ifdef DPAD_REVERSAL_BLOCK_EN
    // opp_dir is 0000 while stationary, so a (non-zero) pend never matches
    block_hit = (pend == opp_dir);
`else
    block_hit = 1'b0;
`endif
    take = commit & ~block_hit & (pend != direction);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      direction   <= '0;
      dir_changed <= 1'b0;
      pend        <= '0;
      pend_v      <= 1'b0;
    end else begin
      dir_changed <= take;
      if (take) direction <= pend;
      // A new request always survives a same-cycle commit of the old entry
      if (req_v) begin
        pend   <= req;
        pend_v <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpad_direction_encoder.sv
module tb_dpad_direction_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l = 1'b0, r = 1'b0, u = 1'b0, d = 1'b0;
  logic       step = 1'b0;
  logic [3:0] direction;
  logic       dir_changed;

  dpad_direction_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .l(l), .r(r), .u(u), .d(d), .step(step),
    .direction(direction), .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dir;
    logic       chg;
  } exp_t;

  typedef struct {
    logic [3:0]  btn;       // {u, d, r, l}
    int unsigned hold;
    logic        do_step;
    logic [3:0]  dir;       // expectation, plain build
    logic        chg;
    logic [3:0]  dir_blk;   // expectation, reversal-block build
    logic        chg_blk;
  } vec_t;

  exp_t       sb[$];
  logic [3:0] exp_dir = 4'b0000;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {u, d, r, l} = b;
  endtask

  task automatic push(input logic [3:0] dv, input logic cv);
    exp_t e;
    e.dir = dv;
    e.chg = cv;
    sb.push_back(e);
  endtask

  // Monitor: every edge is checked 1 ns later
  always begin
    logic st, rs;
    exp_t e;
    @(posedge clk);
    st = step;
    rs = reset;
    #1;
    if (rs) begin
      chk("reset_direction", direction, 4'b0000);
      chk("reset_dir_changed", {3'b000, dir_changed}, 4'b0000);
      exp_dir = 4'b0000;
    end else if (st) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 4'b0001, 4'b0000);
      end else begin
        e = sb.pop_front();
        chk("step_direction", direction, e.dir);
        chk("step_dir_changed", {3'b000, dir_changed}, {3'b000, e.chg});
        exp_dir = e.dir;
      end
    end else begin
      chk("idle_direction", direction, exp_dir);
      chk("idle_dir_changed", {3'b000, dir_changed}, 4'b0000);
    end
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b0001,  3, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0}; // 3-cycle glitch
    vecs[1] = '{4'b0010, 20, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1}; // right
    vecs[2] = '{4'b0000,  0, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0}; // step, nothing pending
    vecs[3] = '{4'b1000,  8, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0}; // up, no step
    vecs[4] = '{4'b0100,  8, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1}; // down wins
    vecs[5] = '{4'b0010,  4, 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1}; // exactly 4-cycle press
    vecs[6] = '{4'b0001,  8, 1'b1, 4'b0001, 1'b1, 4'b0010, 1'b0}; // reversal R->L
    vecs[7] = '{4'b1000,  8, 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1}; // up
    vecs[8] = '{4'b1001,  8, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1}; // L+U same cycle
    vecs[9] = '{4'b0001,  8, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0}; // same heading again

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      set_btn(vecs[i].btn);
      repeat (vecs[i].hold) tick();
      set_btn(4'b0000);
      repeat (10) tick();
      if (vecs[i].do_step) begin
`ifdef DPAD_REVERSAL_BLOCK_EN
        push(vecs[i].dir_blk, vecs[i].chg_blk);
`else
        push(vecs[i].dir, vecs[i].chg);
`endif
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
      end
    end

    // step held for 3 cycles commits once (from 0001)
    set_btn(4'b0100);
    repeat (8) tick();
    set_btn(4'b0000);
    repeat (10) tick();
    push(4'b0100, 1'b1);
    push(4'b0100, 1'b0);
    push(4'b0100, 1'b0);
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    tick();

    // step in the request cycle does not commit; the next step does
    set_btn(4'b0010);
    repeat (5) tick();
    push(4'b0100, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    set_btn(4'b0000);
    repeat (10) tick();
    push(4'b0010, 1'b1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();

    // reset right after a commit, with d mid-debounce
    set_btn(4'b1000);
    repeat (8) tick();
    set_btn(4'b0000);
    repeat (10) tick();
    set_btn(4'b0100);
    repeat (3) tick();
    push(4'b1000, 1'b1);
    step = 1'b1;
    tick();
    step = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    push(4'b0000, 1'b0);   // request only now being generated
    step = 1'b1;
    tick();
    push(4'b0100, 1'b1);
    tick();
    step = 1'b0;
    set_btn(4'b0000);
    repeat (4) tick();

    chk("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
